// File: rtl/uart_msg_tx_pkg.sv
// Shared definitions for the UART message blocks: FSM encodings, ASCII
// trailer bytes and the byte width used by the rx/tx message paths.
package uart_msg_tx_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_WAIT_RDY = 2'd3
  } state_t;

  // Which byte source feeds the transmitter: buffer, then optional CR, LF.
  typedef enum logic [1:0] {
    PH_DATA = 2'd0,
    PH_CR   = 2'd1,
    PH_LF   = 2'd2
  } phase_t;

endpackage

// File: rtl/uart_msg_buf.sv
// Message byte buffer: DEPTH x 8 register file, one synchronous write port
// and one combinational read port. Contents are intentionally not reset.
module uart_msg_buf
  import uart_msg_tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Write port; no reset so the array maps onto plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_msg_tx.sv
// UART message transmitter: streams len bytes from a small buffer to
// uart_ctrl_tx via a tx_start / tx_ready handshake.
// Optional macro UART_MSG_TX_CRLF_EN appends CR LF after the buffer bytes.
//
// state       | meaning
// ST_IDLE     | waiting for send, buffer writable
// ST_ISSUE    | waiting for tx_ready to hand over the next byte
// ST_WAIT_ACK | byte offered, waiting for tx_ready to drop (accepted)
// ST_WAIT_RDY | byte in flight, waiting for tx_ready to return
module uart_msg_tx
  import uart_msg_tx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [AW:0]       len,
  input  logic              send,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              busy,
  output logic              done
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t            state;
  logic [AW:0]       len_q;
  logic [AW-1:0]     index;
  logic [AW:0]       len_clamped;
  logic              last_byte;
  logic [BYTE_W-1:0] rd_data;
  logic [BYTE_W-1:0] cur_byte;

  // Writes are dropped while a message is in flight so it stays coherent.
  uart_msg_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (index),
    .rd_data (rd_data)
  );

  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  assign last_byte   = ({1'b0, index} == (len_q - 1'b1));

`ifdef UART_MSG_TX_CRLF_EN
  phase_t phase;

  // Pick the outgoing byte from the buffer or the fixed trailer.
  always_comb begin
    cur_byte = rd_data;
    case (phase)
      PH_CR:   cur_byte = ASCII_CR;
      PH_LF:   cur_byte = ASCII_LF;
      default: cur_byte = rd_data;
    endcase
  end
`else
  assign cur_byte = rd_data;
`endif

  // Message sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      index    <= '0;
      len_q    <= '0;
`ifdef UART_MSG_TX_CRLF_EN
      phase    <= PH_DATA;
`endif
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (send) begin
            len_q <= len_clamped;
            index <= '0;
`ifdef UART_MSG_TX_CRLF_EN
            phase <= (len_clamped == '0) ? PH_CR : PH_DATA;
            state <= ST_ISSUE;
            busy  <= 1'b1;
`else
            if (len_clamped == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_ISSUE;
              busy  <= 1'b1;
            end
`endif
          end
        end
        ST_ISSUE: begin
          if (tx_ready) begin
            tx_data  <= cur_byte;
            tx_start <= 1'b1;
            state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (!tx_ready) state <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (tx_ready) begin
`ifdef UART_MSG_TX_CRLF_EN
            case (phase)
              PH_DATA: begin
                if (last_byte) phase <= PH_CR;
                else           index <= index + 1'b1;
                state <= ST_ISSUE;
              end
              PH_CR: begin
                phase <= PH_LF;
                state <= ST_ISSUE;
              end
              default: begin
                phase <= PH_DATA;
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            endcase
`else
            if (last_byte) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              index <= index + 1'b1;
              state <= ST_ISSUE;
            end
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
